// File: rtl/mcore_util_pkg.sv
// rtl/mcore_util_pkg.sv - register map, control bit positions and state/mode types for the util fill engine
package mcore_util_pkg;

   localparam logic [7:0] UTIL_REG_ADDR    = 8'h00;
   localparam logic [7:0] UTIL_REG_CTRL    = 8'h04;
   localparam logic [7:0] UTIL_REG_LEN     = 8'h08;
   localparam logic [7:0] UTIL_REG_PATTERN = 8'h0C;
   localparam logic [7:0] UTIL_REG_STEP    = 8'h10;

   // CTRL write bits
   localparam int CTRL_START_BIT    = 0;
   localparam int CTRL_IRQ_EN_BIT   = 3;
   localparam int CTRL_DONE_CLR_BIT = 4;
   localparam int CTRL_MODE_BIT     = 8;

   // STAT read bits (same offset as CTRL)
   localparam int STAT_DONE_BIT = 0;
   localparam int STAT_BUSY_BIT = 1;
   localparam int STAT_ERR_BIT  = 2;

   typedef enum logic [1:0] {
      FILL_IDLE  = 2'd0,
      FILL_ISSUE = 2'd1,
      FILL_DRAIN = 2'd2
   } fill_state_t;

   typedef enum logic {
      FILL_MODE_CONST = 1'b0,
      FILL_MODE_INCR  = 1'b1
   } fill_mode_t;

endpackage

// File: rtl/mcore_fill_issue.sv
// rtl/mcore_fill_issue.sv - beat counters, outstanding throttle and AW/W generation for the fill engine
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_clr                   start pulse: clears counters, loads base address and pattern
//   i_issue_en              engine may issue AW/W beats
//   i_cnt_en                engine accepts write responses
//   i_base_addr, i_len      first beat address, beat count
//   i_pattern, i_step       first beat data, per-beat increment
//   i_mode_incr             1 = incrementing data, 0 = constant data
//   o_aw_*, i_aw_ready      write address channel
//   o_w_*, i_w_ready        write data channel
//   i_b_valid               write response strobe (b_ready is tied high)
//   o_aw_all/o_w_all/o_b_all  all LEN beats issued / written / acknowledged
module mcore_fill_issue
   import mcore_util_pkg::*;
#(
   parameter int DATA_WIDTH      = 32,
   parameter int AXI_ADDR_WIDTH  = 32,
   parameter int LEN_WIDTH       = 16,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_clr,
   input  logic                      i_issue_en,
   input  logic                      i_cnt_en,
   input  logic [AXI_ADDR_WIDTH-1:0] i_base_addr,
   input  logic [LEN_WIDTH-1:0]      i_len,
   input  logic [DATA_WIDTH-1:0]     i_pattern,
   input  logic [DATA_WIDTH-1:0]     i_step,
   input  logic                      i_mode_incr,
   output logic                      o_aw_valid,
   input  logic                      i_aw_ready,
   output logic [AXI_ADDR_WIDTH-1:0] o_aw_addr,
   output logic                      o_w_valid,
   input  logic                      i_w_ready,
   output logic [DATA_WIDTH-1:0]     o_w_data,
   input  logic                      i_b_valid,
   output logic                      o_aw_all,
   output logic                      o_w_all,
   output logic                      o_b_all
);

   localparam int CNT_W = LEN_WIDTH + 1;
   localparam logic [CNT_W-1:0]          MAX_OUT  = CNT_W'(MAX_OUTSTANDING);
   localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_INC = AXI_ADDR_WIDTH'(DATA_WIDTH / 8);

   logic [CNT_W-1:0]          r_aw_cnt;
   logic [CNT_W-1:0]          r_w_cnt;
   logic [CNT_W-1:0]          r_b_cnt;
   logic [AXI_ADDR_WIDTH-1:0] r_aw_addr;
   logic [DATA_WIDTH-1:0]     r_w_data;

   logic [CNT_W-1:0] w_len;
   logic [CNT_W-1:0] w_aw_lead;
   logic             w_aw_valid;
   logic             w_w_valid;
   logic             w_aw_fire;
   logic             w_w_fire;
   logic             w_b_fire;

   assign w_len = {1'b0, i_len};

   // Valids are pure functions of counters that only move on their own
   // handshake, so once raised they stay up until accepted.
   assign w_aw_valid = i_issue_en && (r_aw_cnt < w_len) && ((r_aw_cnt - r_b_cnt) < MAX_OUT);
   assign w_aw_fire  = w_aw_valid && i_aw_ready;
   // A data beat may go in the same cycle as its address, never before it.
   assign w_aw_lead  = r_aw_cnt + CNT_W'(w_aw_fire);
   assign w_w_valid  = i_issue_en && (r_w_cnt < w_len) && (r_w_cnt < w_aw_lead);
   assign w_w_fire   = w_w_valid && i_w_ready;
   // Responses beyond the issued count cannot belong to this run.
   assign w_b_fire   = i_cnt_en && i_b_valid && (r_b_cnt < r_aw_cnt);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_aw_cnt  <= '0;
         r_w_cnt   <= '0;
         r_b_cnt   <= '0;
         r_aw_addr <= '0;
         r_w_data  <= '0;
      end else if (i_clr) begin
         r_aw_cnt  <= '0;
         r_w_cnt   <= '0;
         r_b_cnt   <= '0;
         r_aw_addr <= i_base_addr;
         r_w_data  <= i_pattern;
      end else begin
         if (w_aw_fire) begin
            r_aw_cnt  <= r_aw_cnt + 1'b1;
            r_aw_addr <= r_aw_addr + ADDR_INC;
         end
         if (w_w_fire) begin
            r_w_cnt <= r_w_cnt + 1'b1;
            if (i_mode_incr) begin
               r_w_data <= r_w_data + i_step;
            end
         end
         if (w_b_fire) begin
            r_b_cnt <= r_b_cnt + 1'b1;
         end
      end
   end

   assign o_aw_valid = w_aw_valid;
   assign o_aw_addr  = r_aw_addr;
   assign o_w_valid  = w_w_valid;
   assign o_w_data   = r_w_data;
   assign o_aw_all   = (r_aw_cnt == w_len);
   assign o_w_all    = (r_w_cnt == w_len);
   assign o_b_all    = (r_b_cnt == w_len);

endmodule

// File: rtl/mcore_util_fill.sv
// rtl/mcore_util_fill.sv - register-programmed AXI write fill engine (optional MCORE_UTIL_FILL_IRQ_EN)
// Ports:
//   aclk, aresetn                      clock, asynchronous active-low reset
//   mr_addra/mr_dina/mr_douta          register address, write data, registered read data
//   mr_ena, mr_wea                     access enable, byte write enables (any set = word write)
//   m_axi_aw_*                         write address channel
//   m_axi_w_*                          write data channel
//   m_axi_b_*                          write response channel
//   irq                                done & irq_en, only with MCORE_UTIL_FILL_IRQ_EN
module mcore_util_fill
   import mcore_util_pkg::*;
#(
   parameter int DATA_WIDTH      = 32,
   parameter int ADDR_WIDTH      = 32,
   parameter int AXI_ADDR_WIDTH  = 32,
   parameter int LEN_WIDTH       = 16,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   input  logic [ADDR_WIDTH-1:0]     mr_addra,
   input  logic [DATA_WIDTH-1:0]     mr_dina,
   output logic [DATA_WIDTH-1:0]     mr_douta,
   input  logic                      mr_ena,
   input  logic [DATA_WIDTH/8-1:0]   mr_wea,
   output logic [AXI_ADDR_WIDTH-1:0] m_axi_aw_addr,
   output logic [2:0]                m_axi_aw_prot,
   output logic                      m_axi_aw_valid,
   input  logic                      m_axi_aw_ready,
   output logic [DATA_WIDTH-1:0]     m_axi_w_data,
   output logic [DATA_WIDTH/8-1:0]   m_axi_w_strb,
   output logic                      m_axi_w_valid,
   input  logic                      m_axi_w_ready,
   input  logic [1:0]                m_axi_b_resp,
   input  logic                      m_axi_b_valid,
`ifdef MCORE_UTIL_FILL_IRQ_EN
   output logic                      m_axi_b_ready,
   output logic                      irq
`else
   output logic                      m_axi_b_ready
`endif
);

   fill_state_t               r_state;
   fill_state_t               w_state_nxt;
   logic [AXI_ADDR_WIDTH-1:0] r_addr;
   logic [LEN_WIDTH-1:0]      r_len;
   logic [DATA_WIDTH-1:0]     r_pattern;
   logic [DATA_WIDTH-1:0]     r_step;
   fill_mode_t                r_mode;
   logic                      r_done;
   logic                      r_err;
   logic [DATA_WIDTH-1:0]     r_rdata;
   logic [DATA_WIDTH-1:0]     w_rd_data;

   logic [7:0] w_reg_addr;
   logic       w_wr;
   logic       w_rd;
   logic       w_start_go;
   logic       w_done_set;
   logic       w_done_clr;
   logic       w_busy;
   logic       w_issue_en;
   logic       w_aw_all;
   logic       w_w_all;
   logic       w_b_all;
   logic       w_unused_addr;

   assign w_reg_addr    = mr_addra[7:0];
   assign w_unused_addr = ^mr_addra[ADDR_WIDTH-1:8];
   assign w_wr          = mr_ena && (|mr_wea);
   assign w_rd          = mr_ena && !(|mr_wea);
   assign w_start_go    = w_wr && (w_reg_addr == UTIL_REG_CTRL) &&
                          mr_dina[CTRL_START_BIT] && (r_state == FILL_IDLE);
   // A zero-length start completes on the start edge without leaving IDLE.
   assign w_done_set    = ((r_state == FILL_DRAIN) && w_b_all) ||
                          (w_start_go && (r_len == '0));

`ifdef MCORE_UTIL_FILL_IRQ_EN
   logic r_irq_en;
   logic r_irq;
   assign w_done_clr = w_wr && (w_reg_addr == UTIL_REG_CTRL) && mr_dina[CTRL_DONE_CLR_BIT];
   assign irq        = r_irq;
`else
   assign w_done_clr = 1'b0;
`endif

   // FSM: state register
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state <= FILL_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM: next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         FILL_IDLE:  if (w_start_go && (r_len != '0)) w_state_nxt = FILL_ISSUE;
         FILL_ISSUE: if (w_aw_all && w_w_all)         w_state_nxt = FILL_DRAIN;
         FILL_DRAIN: if (w_b_all)                     w_state_nxt = FILL_IDLE;
         default:                                     w_state_nxt = FILL_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      w_busy     = (r_state != FILL_IDLE);
      w_issue_en = (r_state == FILL_ISSUE);
   end

   // Register file and status
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_addr    <= '0;
         r_len     <= '0;
         r_pattern <= '0;
         r_step    <= '0;
         r_mode    <= FILL_MODE_CONST;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_rdata   <= '0;
`ifdef MCORE_UTIL_FILL_IRQ_EN
         r_irq_en  <= 1'b0;
         r_irq     <= 1'b0;
`endif
      end else begin
         // Configuration is frozen while a run is in flight.
         if (w_wr && !w_busy) begin
            case (w_reg_addr)
               UTIL_REG_ADDR:    r_addr    <= mr_dina[AXI_ADDR_WIDTH-1:0];
               UTIL_REG_LEN:     r_len     <= mr_dina[LEN_WIDTH-1:0];
               UTIL_REG_PATTERN: r_pattern <= mr_dina;
               UTIL_REG_STEP:    r_step    <= mr_dina;
               UTIL_REG_CTRL:    r_mode    <= fill_mode_t'(mr_dina[CTRL_MODE_BIT]);
               default: ;
            endcase
         end
`ifdef MCORE_UTIL_FILL_IRQ_EN
         if (w_wr && (w_reg_addr == UTIL_REG_CTRL)) begin
            r_irq_en <= mr_dina[CTRL_IRQ_EN_BIT];
         end
         r_irq <= r_done & r_irq_en;
`endif
         if (w_done_set) begin
            r_done <= 1'b1;
         end else if (w_start_go || w_done_clr) begin
            r_done <= 1'b0;
         end
         if (w_start_go) begin
            r_err <= 1'b0;
         end else if (w_busy && m_axi_b_valid && (m_axi_b_resp != 2'b00)) begin
            r_err <= 1'b1;
         end
         if (w_rd) begin
            r_rdata <= w_rd_data;
         end
      end
   end

   always_comb begin
      w_rd_data = '0;
      case (w_reg_addr)
         UTIL_REG_ADDR:    w_rd_data[AXI_ADDR_WIDTH-1:0] = r_addr;
         UTIL_REG_CTRL: begin
            w_rd_data[STAT_DONE_BIT] = r_done;
            w_rd_data[STAT_BUSY_BIT] = w_busy;
            w_rd_data[STAT_ERR_BIT]  = r_err;
            w_rd_data[CTRL_MODE_BIT] = r_mode;
`ifdef MCORE_UTIL_FILL_IRQ_EN
            w_rd_data[CTRL_IRQ_EN_BIT] = r_irq_en;
`endif
         end
         UTIL_REG_LEN:     w_rd_data[LEN_WIDTH-1:0] = r_len;
         UTIL_REG_PATTERN: w_rd_data = r_pattern;
         UTIL_REG_STEP:    w_rd_data = r_step;
         default: ;
      endcase
   end

   mcore_fill_issue #(
      .DATA_WIDTH      (DATA_WIDTH),
      .AXI_ADDR_WIDTH  (AXI_ADDR_WIDTH),
      .LEN_WIDTH       (LEN_WIDTH),
      .MAX_OUTSTANDING (MAX_OUTSTANDING)
   ) u_issue (
      .i_clk       (aclk),
      .i_rst_n     (aresetn),
      .i_clr       (w_start_go),
      .i_issue_en  (w_issue_en),
      .i_cnt_en    (w_busy),
      .i_base_addr (r_addr),
      .i_len       (r_len),
      .i_pattern   (r_pattern),
      .i_step      (r_step),
      .i_mode_incr (r_mode == FILL_MODE_INCR),
      .o_aw_valid  (m_axi_aw_valid),
      .i_aw_ready  (m_axi_aw_ready),
      .o_aw_addr   (m_axi_aw_addr),
      .o_w_valid   (m_axi_w_valid),
      .i_w_ready   (m_axi_w_ready),
      .o_w_data    (m_axi_w_data),
      .i_b_valid   (m_axi_b_valid),
      .o_aw_all    (w_aw_all),
      .o_w_all     (w_w_all),
      .o_b_all     (w_b_all)
   );

   assign mr_douta      = r_rdata;
   assign m_axi_aw_prot = 3'b000;
   assign m_axi_w_strb  = '1;
   assign m_axi_b_ready = 1'b1;

endmodule

// File: tb/tb_mcore_util_fill.sv
// tb/tb_mcore_util_fill.sv - directed self-checking bench for mcore_util_fill
module tb_mcore_util_fill;

   logic        aclk;
   logic        aresetn;
   logic [31:0] mr_addra;
   logic [31:0] mr_dina;
   logic [31:0] mr_douta;
   logic        mr_ena;
   logic [3:0]  mr_wea;
   logic [31:0] m_axi_aw_addr;
   logic [2:0]  m_axi_aw_prot;
   logic        m_axi_aw_valid;
   logic        m_axi_aw_ready;
   logic [31:0] m_axi_w_data;
   logic [3:0]  m_axi_w_strb;
   logic        m_axi_w_valid;
   logic        m_axi_w_ready;
   logic [1:0]  m_axi_b_resp;
   logic        m_axi_b_valid;
   logic        m_axi_b_ready;

   int total = 0;
   int bad   = 0;

   // slave model controls (written by the directed sequence only)
   logic aw_rdy_en  = 1'b1;
   logic w_tog      = 1'b0;
   logic b_en       = 1'b1;
   int   err_beat   = -1;
   int   resync_req = 0;

   // slave model state (written by the responder only)
   int          resync_seen  = 0;
   int          aw_n         = 0;
   int          w_n          = 0;
   int          b_sent       = 0;
   int          order_viol   = 0;
   int          valid_cycles = 0;
   logic [31:0] aw_log [0:15];
   logic [31:0] w_log  [0:15];

   mcore_util_fill dut (
      .aclk           (aclk),
      .aresetn        (aresetn),
      .mr_addra       (mr_addra),
      .mr_dina        (mr_dina),
      .mr_douta       (mr_douta),
      .mr_ena         (mr_ena),
      .mr_wea         (mr_wea),
      .m_axi_aw_addr  (m_axi_aw_addr),
      .m_axi_aw_prot  (m_axi_aw_prot),
      .m_axi_aw_valid (m_axi_aw_valid),
      .m_axi_aw_ready (m_axi_aw_ready),
      .m_axi_w_data   (m_axi_w_data),
      .m_axi_w_strb   (m_axi_w_strb),
      .m_axi_w_valid  (m_axi_w_valid),
      .m_axi_w_ready  (m_axi_w_ready),
      .m_axi_b_resp   (m_axi_b_resp),
      .m_axi_b_valid  (m_axi_b_valid),
      .m_axi_b_ready  (m_axi_b_ready)
   );

   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   // Slave responder: observes handshakes on the falling edge, drives readies
   // and one-per-cycle write responses just after the rising edge.
   initial begin
      m_axi_aw_ready = 1'b0;
      m_axi_w_ready  = 1'b0;
      m_axi_b_valid  = 1'b0;
      m_axi_b_resp   = 2'b00;
      forever begin
         @(negedge aclk);
         if (resync_req != resync_seen) begin
            resync_seen = resync_req;
            aw_n = 0;
            w_n = 0;
            b_sent = 0;
         end
         if (m_axi_aw_valid && m_axi_aw_ready) begin
            if (aw_n < 16) aw_log[aw_n] = m_axi_aw_addr;
            aw_n++;
         end
         if (m_axi_w_valid && m_axi_w_ready) begin
            if (w_n < 16) w_log[w_n] = m_axi_w_data;
            w_n++;
            if (w_n > aw_n) order_viol++;
         end
         if (m_axi_aw_valid || m_axi_w_valid) valid_cycles++;
         @(posedge aclk);
         #1;
         m_axi_aw_ready = aw_rdy_en;
         m_axi_w_ready  = w_tog ? ~m_axi_w_ready : 1'b1;
         if (b_en && (b_sent < ((aw_n < w_n) ? aw_n : w_n))) begin
            m_axi_b_valid = 1'b1;
            m_axi_b_resp  = (b_sent == err_beat) ? 2'b10 : 2'b00;
            b_sent++;
         end else begin
            m_axi_b_valid = 1'b0;
            m_axi_b_resp  = 2'b00;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic reg_wr(input logic [7:0] addr, input logic [31:0] data);
      @(posedge aclk); #1;
      mr_ena   = 1'b1;
      mr_wea   = 4'hF;
      mr_addra = {24'h0, addr};
      mr_dina  = data;
      @(posedge aclk); #1;
      mr_ena   = 1'b0;
      mr_wea   = 4'h0;
   endtask

   task automatic reg_rd(input logic [7:0] addr, output logic [31:0] data);
      @(posedge aclk); #1;
      mr_ena   = 1'b1;
      mr_wea   = 4'h0;
      mr_addra = {24'h0, addr};
      @(posedge aclk); #1;
      mr_ena   = 1'b0;
      data     = mr_douta;
   endtask

   task automatic rd_chk(input string tag, input logic [7:0] addr, input logic [31:0] exp);
      logic [31:0] d;
      reg_rd(addr, d);
      check(tag, d, exp);
   endtask

   task automatic wait_done(input string tag);
      logic [31:0] d;
      logic        seen;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         reg_rd(8'h04, d);
         seen = d[0];
      end
      check(tag, {31'h0, seen}, 32'h1);
   endtask

   task automatic resync();
      resync_req++;
      repeat (2) @(posedge aclk);
      #1;
   endtask

   initial begin
      int vc0;
      aresetn  = 1'b0;
      mr_ena   = 1'b0;
      mr_wea   = 4'h0;
      mr_addra = 32'h0;
      mr_dina  = 32'h0;
      repeat (3) @(posedge aclk);
      #1;

      // reset state
      check("rst_douta", mr_douta, 32'h0);
      check("rst_awvalid", {31'h0, m_axi_aw_valid}, 32'h0);
      check("rst_wvalid", {31'h0, m_axi_w_valid}, 32'h0);
      check("rst_awaddr", m_axi_aw_addr, 32'h0);
      check("rst_wdata", m_axi_w_data, 32'h0);
      check("rst_prot", {29'h0, m_axi_aw_prot}, 32'h0);
      check("rst_strb", {28'h0, m_axi_w_strb}, 32'hF);
      check("rst_bready", {31'h0, m_axi_b_ready}, 32'h1);
      aresetn = 1'b1;
      rd_chk("rst_stat", 8'h04, 32'h0);
      rd_chk("rst_len", 8'h08, 32'h0);
      rd_chk("unmapped_rd", 8'h20, 32'h0);

      // constant fill, 8 beats
      resync();
      reg_wr(8'h00, 32'h7000_0000);
      reg_wr(8'h08, 32'd8);
      reg_wr(8'h0C, 32'hCAFE_0000);
      reg_wr(8'h20, 32'hFFFF_FFFF);
      reg_wr(8'h04, 32'h0000_0001);
      rd_chk("const_busy", 8'h04, 32'h2);
      wait_done("const_done");
      check("const_aw_n", aw_n, 8);
      check("const_w_n", w_n, 8);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("const_addr%0d", i), aw_log[i], 32'h7000_0000 + 32'(4 * i));
         check($sformatf("const_data%0d", i), w_log[i], 32'hCAFE_0000);
      end
      rd_chk("const_stat", 8'h04, 32'h1);
      rd_chk("unmapped_wr", 8'h20, 32'h0);

      // incrementing fill
      resync();
      reg_wr(8'h0C, 32'hBEEF_0000);
      reg_wr(8'h10, 32'd1);
      reg_wr(8'h04, 32'h0000_0101);
      wait_done("incr_done");
      check("incr_w_n", w_n, 8);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("incr_data%0d", i), w_log[i], 32'hBEEF_0000 + 32'(i));
      end
      check("incr_addr7", aw_log[7], 32'h7000_001C);
      rd_chk("incr_stat", 8'h04, 32'h101);

      // outstanding limit with responses withheld
      resync();
      b_en = 1'b0;
      reg_wr(8'h00, 32'h0000_1000);
      reg_wr(8'h08, 32'd10);
      reg_wr(8'h04, 32'h0000_0001);
      repeat (20) @(posedge aclk);
      #1;
      check("stall_aw_n", aw_n, 4);
      check("stall_w_n", w_n, 4);
      check("stall_awvalid", {31'h0, m_axi_aw_valid}, 32'h0);
      rd_chk("stall_busy", 8'h04, 32'h2);
      b_en = 1'b1;
      wait_done("stall_done");
      check("stall_aw_total", aw_n, 10);
      check("stall_b_total", b_sent, 10);
      check("stall_addr9", aw_log[9], 32'h0000_1024);

      // W ready toggling, error response on beat 3
      resync();
      w_tog    = 1'b1;
      err_beat = 3;
      reg_wr(8'h08, 32'd8);
      reg_wr(8'h04, 32'h0000_0001);
      wait_done("err_done");
      w_tog    = 1'b0;
      err_beat = -1;
      check("err_order", order_viol, 0);
      check("err_w_n", w_n, 8);
      check("err_b_n", b_sent, 8);
      rd_chk("err_stat", 8'h04, 32'h5);

      // zero length: done on start edge, err cleared, no traffic
      resync();
      vc0 = valid_cycles;
      reg_wr(8'h08, 32'd0);
      reg_wr(8'h04, 32'h0000_0001);
      rd_chk("len0_stat", 8'h04, 32'h1);
      repeat (5) @(posedge aclk);
      #1;
      check("len0_no_valid", valid_cycles - vc0, 0);

      // start and LEN write while busy are ignored
      resync();
      b_en = 1'b0;
      reg_wr(8'h00, 32'h0000_2000);
      reg_wr(8'h08, 32'd6);
      reg_wr(8'h04, 32'h0000_0001);
      repeat (10) @(posedge aclk);
      #1;
      reg_wr(8'h08, 32'd2);
      reg_wr(8'h04, 32'h0000_0001);
      repeat (4) @(posedge aclk);
      #1;
      check("busy_aw_n", aw_n, 4);
      rd_chk("busy_len", 8'h08, 32'd6);
      b_en = 1'b1;
      wait_done("busy_done");
      check("busy_aw_total", aw_n, 6);
      check("busy_addr5", aw_log[5], 32'h0000_2014);

      // reset in the middle of a run
      resync();
      reg_wr(8'h08, 32'd8);
      reg_wr(8'h04, 32'h0000_0001);
      for (int i = 0; i < 100 && aw_n < 3; i++) begin
         @(posedge aclk); #1;
      end
      check("midrst_reached", {31'h0, aw_n >= 3}, 32'h1);
      aresetn = 1'b0;
      #1;
      check("midrst_awvalid", {31'h0, m_axi_aw_valid}, 32'h0);
      check("midrst_wvalid", {31'h0, m_axi_w_valid}, 32'h0);
      repeat (2) @(posedge aclk);
      #1;
      aresetn = 1'b1;
      check("midrst_douta", mr_douta, 32'h0);
      resync();
      rd_chk("midrst_addr", 8'h00, 32'h0);
      rd_chk("midrst_len", 8'h08, 32'h0);
      rd_chk("midrst_pat", 8'h0C, 32'h0);
      rd_chk("midrst_stat", 8'h04, 32'h0);

      // fresh run after reset
      resync();
      reg_wr(8'h00, 32'h0000_3000);
      reg_wr(8'h08, 32'd3);
      reg_wr(8'h0C, 32'h0000_0011);
      reg_wr(8'h10, 32'h0000_0010);
      reg_wr(8'h04, 32'h0000_0101);
      wait_done("fresh_done");
      check("fresh_aw_n", aw_n, 3);
      check("fresh_data0", w_log[0], 32'h0000_0011);
      check("fresh_data2", w_log[2], 32'h0000_0031);
      check("fresh_addr2", aw_log[2], 32'h0000_3008);
      rd_chk("fresh_stat", 8'h04, 32'h101);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
